mem_wb_elastic: RTL and testbench
=================================

Name: mem_wb_elastic

Overview:
- Parametrised successor to the MEM/WB pipeline register. Carries NCH register-write channels (address, enable, data) from the memory-access stage to the write-back stage.
- Adds a valid/ready handshake with a 2-entry skid buffer, so write-back can stall without losing writes, and a synchronous flush.
- Suppresses writes that target register 0.
- Sits between the MEM stage and the register-file write ports.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, write data width.
- NCH, 2, write channels per instruction (for example GPR plus HI/LO); range 1..4.
- ZERO_SUPPRESS, 1, when 1 the enable of any channel whose address is 0 is cleared at capture.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous pipeline flush, active-high.
- in_valid  in  1  MEM stage presents a valid instruction.
- in_ready  out  1  block can accept this cycle.
- in_wd  in  NCH*ADDR_W  destination addresses; channel k occupies bits [k*ADDR_W +: ADDR_W].
- in_wreg  in  NCH  per-channel write enables.
- in_wdata  in  NCH*DATA_W  write data; channel k occupies bits [k*DATA_W +: DATA_W].
- out_valid  out  1  write-back entry valid.
- out_ready  in  1  write-back consumes the entry this cycle.
- out_wd  out  NCH*ADDR_W  write-back addresses.
- out_wreg  out  NCH  write-back enables.
- out_wdata  out  NCH*DATA_W  write-back data.
- occupancy  out  2  number of entries held (0..2).

Behaviour:
- Storage:
  - main register drives the out_* ports directly.
  - skid register holds one entry behind it.
- States:
  - EMPTY: occupancy 0.
  - HALF: main valid, occupancy 1.
  - FULL: main and skid valid, occupancy 2.
- Handshake signals:
  - in_ready = !skid_valid, a registered-state decode with no combinational path from out_ready.
  - Accept (in_fire) = in_valid & in_ready.
  - Drain (out_fire) = out_valid & out_ready.
- Transitions:
  - EMPTY: in_fire -> HALF, main <= in.
  - HALF:
    - in_fire & out_fire -> HALF, main <= in.
    - in_fire & !out_fire -> FULL, skid <= in.
    - !in_fire & out_fire -> EMPTY.
    - otherwise hold.
  - FULL: out_fire -> HALF, main <= skid, skid cleared; otherwise hold. in_valid is ignored because in_ready=0.
- Latency and throughput:
  - Latency is 1 cycle from in_fire to out_valid when EMPTY.
  - Sustained throughput is 1 entry/cycle when out_ready is held high.
  - Entries leave in strict arrival order.
- Invalid entries:
  - Whenever main is invalid, out_wd, out_wreg and out_wdata are all zero (NOP address, write disabled, zero word).
  - The main payload is cleared on the transition to EMPTY.
- Capture rule (ZERO_SUPPRESS=1):
  - stored wreg[k] = in_wreg[k] & (in_wd[k] != 0).
  - wd and wdata are stored unmodified.
  - Each channel captures its own enable, address and data; no channel is cross-wired.
- Flush:
  - Next edge: state EMPTY, all outputs zero, occupancy 0, in_ready 1.
  - An in_fire in the flush cycle is discarded.
  - out_fire in the flush cycle is still seen by the consumer, because the outputs are combinational from main.
- Reset:
  - rst has priority over flush.
  - Reset values: out_valid 0, out_wd 0, out_wreg 0, out_wdata 0, occupancy 0, in_ready 1.
  - Reset asserted mid-stream drops both held entries.
- Simultaneous events:
  - In FULL with out_fire, the skid entry moves to main in the same edge; the new in_ready=1 takes effect the following cycle.
- Widths: all payload is passed through unchanged, with no arithmetic. occupancy is saturated at 2 by construction.

Decomposition:
- Shared package (defines):
  - RstEnable, WriteDisable, NOPRegAddr, ZeroWord.
  - State encoding ST_EMPTY=2'd0, ST_HALF=2'd1, ST_FULL=2'd2.
- Natural sub-module: wb_payload_reg, a single NCH-channel payload register with load, clear and zero-suppress.
  - It is instantiated twice, once as main and once as skid.
  - The parent holds the FSM and the handshake logic.

Test Plan:
1. Reset then single write: rst 2 cycles; in_valid=1, in_wd ch0=5'd3, wreg=2'b01, wdata ch0=32'h1234_5678, out_ready=1 -> next cycle out_valid=1, out_wd ch0=3, out_wreg=01, out_wdata ch0=32'h1234_5678; then out_valid=0 and all outputs 0.
2. Back-pressure: out_ready=0, push A=32'hA, B=32'hB on consecutive cycles -> occupancy 1 then 2, in_ready=0; raise out_ready -> A then B on consecutive cycles, no loss or duplication.
3. Zero suppress: in_wd ch0=0 and ch1=7, wreg=2'b11 -> out_wreg=2'b10, out_wd ch0=0.
4. Flush in FULL with in_valid=1 -> next cycle occupancy 0, out_valid 0, in_ready 1; the flushed-cycle input never appears at the output.
5. Streaming: 16 entries with out_ready=1 -> one output per cycle, ordered, latency 1; then toggle out_ready pseudo-randomly and check order against a scoreboard.
6. rst asserted while FULL, concurrent with flush -> reset values on every output next cycle.

Source files
------------

// File: rtl/mem_wb_elastic_pkg.sv
// Shared constants and state encoding for the elastic MEM/WB register.
// Imported by the payload register and the top.
package mem_wb_elastic_pkg;

    localparam logic        RstEnable    = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_wb_elastic_wb_payload_reg.sv
// One NCH-channel write-back payload register.
// Clear wins over load; the write enable of an address-0 channel is dropped at load.
module wb_payload_reg
    import mem_wb_elastic_pkg::*;
#(
    parameter int ADDR_W        = 5,
    parameter int DATA_W        = 32,
    parameter int NCH           = 2,
    parameter int ZERO_SUPPRESS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  clear_i,
    input  logic [NCH*ADDR_W-1:0] wd_i,
    input  logic [NCH-1:0]        wreg_i,
    input  logic [NCH*DATA_W-1:0] wdata_i,
    output logic [NCH*ADDR_W-1:0] wd_o,
    output logic [NCH-1:0]        wreg_o,
    output logic [NCH*DATA_W-1:0] wdata_o
);

    logic [NCH*ADDR_W-1:0] wd_q;
    logic [NCH-1:0]        wreg_q;
    logic [NCH-1:0]        wreg_d;
    logic [NCH*DATA_W-1:0] wdata_q;

    always_comb begin
        wreg_d = wreg_i;
        for (int k = 0; k < NCH; k++) begin
            if (ZERO_SUPPRESS != 0 &&
                wd_i[k*ADDR_W +: ADDR_W] == '0) begin
                wreg_d[k] = WriteDisable;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable || clear_i) begin
            wd_q    <= '0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else if (load_i) begin
            wd_q    <= wd_i;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_i;
        end
    end

    assign wd_o    = wd_q;
    assign wreg_o  = wreg_q;
    assign wdata_o = wdata_q;

endmodule

// File: rtl/mem_wb_elastic.sv
// Elastic MEM/WB register: main + skid entries behind a valid/ready handshake.
// in_ready is decoded from registered state only, never from out_ready.
module mem_wb_elastic
    import mem_wb_elastic_pkg::*;
#(
    parameter int ADDR_W        = 5,
    parameter int DATA_W        = 32,
    parameter int NCH           = 2,
    parameter int ZERO_SUPPRESS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NCH*ADDR_W-1:0] in_wd,
    input  logic [NCH-1:0]        in_wreg,
    input  logic [NCH*DATA_W-1:0] in_wdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NCH*ADDR_W-1:0] out_wd,
    output logic [NCH-1:0]        out_wreg,
    output logic [NCH*DATA_W-1:0] out_wdata,
    output logic [1:0]            occupancy
);

    state_t state_q, state_d;

    logic in_fire, out_fire;
    logic main_load, main_clr, main_sel_skid;
    logic skid_load, skid_clr;

    logic [NCH*ADDR_W-1:0] skid_wd, main_wd_in;
    logic [NCH-1:0]        skid_wreg, main_wreg_in;
    logic [NCH*DATA_W-1:0] skid_wdata, main_wdata_in;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        unique case (state_q)
            ST_HALF: occupancy = 2'd1;
            ST_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        main_load     = 1'b0;
        main_clr      = 1'b0;
        main_sel_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clr      = 1'b0;
        if (flush) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d   = ST_HALF;
                        main_load = 1'b1;
                    end
                end
                ST_HALF: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        state_d   = ST_FULL;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d  = ST_EMPTY;
                        main_clr = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d       = ST_HALF;
                        main_load     = 1'b1;
                        main_sel_skid = 1'b1;
                        skid_clr      = 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    assign main_wd_in    = main_sel_skid ? skid_wd    : in_wd;
    assign main_wreg_in  = main_sel_skid ? skid_wreg  : in_wreg;
    assign main_wdata_in = main_sel_skid ? skid_wdata : in_wdata;

    wb_payload_reg #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .NCH           (NCH),
        .ZERO_SUPPRESS (ZERO_SUPPRESS)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .load_i  (main_load),
        .clear_i (main_clr),
        .wd_i    (main_wd_in),
        .wreg_i  (main_wreg_in),
        .wdata_i (main_wdata_in),
        .wd_o    (out_wd),
        .wreg_o  (out_wreg),
        .wdata_o (out_wdata)
    );

    wb_payload_reg #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .NCH           (NCH),
        .ZERO_SUPPRESS (ZERO_SUPPRESS)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clr),
        .wd_i    (in_wd),
        .wreg_i  (in_wreg),
        .wdata_i (in_wdata),
        .wd_o    (skid_wd),
        .wreg_o  (skid_wreg),
        .wdata_o (skid_wdata)
    );

endmodule

// File: tb/tb_mem_wb_elastic.sv
// Bench for mem_wb_elastic: queue model checked every cycle plus directed literals.
// Default parameters (ADDR_W=5, DATA_W=32, NCH=2, ZERO_SUPPRESS=1).
module tb_mem_wb_elastic;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NC = 2;

    typedef struct packed {
        logic [NC*AW-1:0] wd;
        logic [NC-1:0]    wreg;
        logic [NC*DW-1:0] wdata;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [NC*AW-1:0] in_wd;
    logic [NC-1:0]    in_wreg;
    logic [NC*DW-1:0] in_wdata;
    logic             out_valid;
    logic             out_ready;
    logic [NC*AW-1:0] out_wd;
    logic [NC-1:0]    out_wreg;
    logic [NC*DW-1:0] out_wdata;
    logic [1:0]       occupancy;

    int   checks   = 0;
    int   failures = 0;
    bit   chk_en   = 1'b0;
    ent_t mq[$];

    mem_wb_elastic dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_wd     (in_wd),
        .in_wreg   (in_wreg),
        .in_wdata  (in_wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_wd    (out_wd),
        .out_wreg  (out_wreg),
        .out_wdata (out_wdata),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic ent_t capture(input logic [NC*AW-1:0] wd,
                                     input logic [NC-1:0] wreg,
                                     input logic [NC*DW-1:0] wdata);
        ent_t e;
        e.wd    = wd;
        e.wreg  = wreg;
        e.wdata = wdata;
        for (int k = 0; k < NC; k++)
            if (wd[k*AW +: AW] == '0) e.wreg[k] = 1'b0;
        return e;
    endfunction

    // Model: a FIFO of depth 2; reset/flush empty it.
    always @(posedge clk) begin
        bit acc, drn;
        acc = in_valid && (mq.size() < 2);
        drn = out_ready && (mq.size() > 0);
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(capture(in_wd, in_wreg, in_wdata));
        end
    end

    always @(negedge clk) begin
        ent_t e;
        if (chk_en) begin
            e = '0;
            if (mq.size() > 0) e = mq[0];
            chk("m_valid", 64'(out_valid), 64'(mq.size() > 0));
            chk("m_wd", 64'(out_wd), 64'(e.wd));
            chk("m_wreg", 64'(out_wreg), 64'(e.wreg));
            chk("m_wdata", out_wdata, e.wdata);
            chk("m_occ", 64'(occupancy), 64'(mq.size()));
            chk("m_ready", 64'(in_ready), 64'(mq.size() < 2));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] wd0,
                        input logic [DW-1:0] d0);
        in_valid = 1'b1;
        in_wd    = {5'd9, wd0};
        in_wreg  = 2'b01;
        in_wdata = {32'hCAFE_0000, d0};
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_wd = '0; in_wreg = '0;
        in_wdata = '0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_wdata", out_wdata, 64'd0);

        // Single write, latency 1
        in_valid = 1'b1; in_wd = {5'd0, 5'd3}; in_wreg = 2'b01;
        in_wdata = {32'h0, 32'h1234_5678}; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_wd", 64'(out_wd), 64'h003);
        chk("t1_wreg", 64'(out_wreg), 64'h1);
        chk("t1_wdata", out_wdata, 64'h1234_5678);
        step();
        chk("t1_empty_v", 64'(out_valid), 64'd0);
        chk("t1_empty_wd", 64'(out_wd), 64'd0);
        chk("t1_empty_d", out_wdata, 64'd0);

        // Back-pressure
        out_ready = 1'b0;
        push(5'd1, 32'hA); step();
        chk("t2_occ1", 64'(occupancy), 64'd1);
        push(5'd2, 32'hB); step();
        in_valid = 1'b0;
        chk("t2_occ2", 64'(occupancy), 64'd2);
        chk("t2_ready0", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        chk("t2_A", 64'(out_wdata[31:0]), 64'hA);
        step();
        chk("t2_B", 64'(out_wdata[31:0]), 64'hB);
        chk("t2_ready_back", 64'(in_ready), 64'd1);
        step();
        chk("t2_drained", 64'(out_valid), 64'd0);

        // Zero suppress
        in_valid = 1'b1; in_wd = {5'd7, 5'd0}; in_wreg = 2'b11;
        in_wdata = {32'h7777_7777, 32'h0000_0001};
        step();
        in_valid = 1'b0;
        chk("t3_wreg", 64'(out_wreg), 64'h2);
        chk("t3_wd", 64'(out_wd), 64'(10'b00111_00000));
        chk("t3_wdata", out_wdata, 64'h7777_7777_0000_0001);
        step();

        // Flush in FULL with a concurrent input
        out_ready = 1'b0;
        push(5'd4, 32'h44); step();
        push(5'd5, 32'h55); step();
        push(5'd6, 32'hDEAD); flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("t4_occ", 64'(occupancy), 64'd0);
        chk("t4_valid", 64'(out_valid), 64'd0);
        chk("t4_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step(); step();
        chk("t4_no_ghost", 64'(out_valid), 64'd0);

        // Streaming 16 entries
        for (int i = 0; i < 16; i++) begin
            push(5'(i + 1), 32'(i * 3 + 1));
            step();
            chk("t5_stream", 64'(out_wdata[31:0]), 64'(i * 3 + 1));
        end
        in_valid = 1'b0;
        step();
        chk("t5_end", 64'(out_valid), 64'd0);

        // Random back-pressure, order checked by model
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_wd     = 10'($urandom);
            in_wreg   = 2'($urandom);
            in_wdata  = {32'(i), $urandom};
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step(); step(); step();

        // Reset with flush while FULL
        out_ready = 1'b0;
        push(5'd10, 32'h10); step();
        push(5'd11, 32'h11); step();
        in_valid = 1'b0;
        chk("t6_full", 64'(occupancy), 64'd2);
        rst = 1'b1; flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0;
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_wd", 64'(out_wd), 64'd0);
        chk("t6_wreg", 64'(out_wreg), 64'd0);
        chk("t6_wdata", out_wdata, 64'd0);
        chk("t6_occ", 64'(occupancy), 64'd0);
        chk("t6_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
